// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 VGA timing constants shared by the sync generator and the graphics blocks
//
// Purpose : single source of the horizontal/vertical timing numbers and the
//           coordinate width so every frame-level block agrees on them.
// Contents: H_*/V_* timing constants, H_TOTAL/V_TOTAL, CLK_DIV, COORD_W and
//           in_window(), an inclusive range test on a coordinate.
package vga_pkg;

    localparam int COORD_W   = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int CLK_DIV   = 4;

    function automatic logic in_window(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo-MAX counter with a wrap strobe
//
// Purpose : counts 0..MAX-1 while en is high, wrapping to 0 after MAX-1.
// Ports   : clk, reset (async, active-high)
//           en   - advance on this clk edge
//           q    - registered count
//           wrap - high when the next enabled edge returns q to 0
module mod_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    // Qualified by en so a chained counter can use it directly as its enable.
    assign wrap = en && (q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LAST) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running VGA timing generator (pixel clock = clk / CLK_DIV)
//
// Purpose : produces pixel coordinates, video_on, registered hsync/vsync and a
//           frame-start pulse for the downstream graphics blocks.
// Ports   : clk, reset (async, active-high)
//           hsync, vsync - registered sync, SYNC_ACTIVE while inside the window
//           video_on     - x/y inside the visible area
//           p_tick       - one clk high per pixel period
//           x, y         - pixel / line counters
//           frame_tick   - one clk pulse after x/y wrap to 0/0
module vga_sync_gen #(
    parameter int   H_DISPLAY   = vga_pkg::H_DISPLAY,
    parameter int   H_FRONT     = vga_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BACK      = vga_pkg::H_BACK,
    parameter int   V_DISPLAY   = vga_pkg::V_DISPLAY,
    parameter int   V_FRONT     = vga_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BACK      = vga_pkg::V_BACK,
    parameter int   CLK_DIV     = vga_pkg::CLK_DIV,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    import vga_pkg::COORD_W;
    import vga_pkg::in_window;

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]   div;
    logic               div_wrap;
    logic               x_wrap;
    logic               y_en;
    logic               y_wrap;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

    mod_counter #(.MAX(CLK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (div),
        .wrap  (div_wrap)
    );

    assign p_tick = div_wrap;

    mod_counter #(.MAX(H_TOT), .W(COORD_W)) u_x (
        .clk   (clk),
        .reset (reset),
        .en    (p_tick),
        .q     (x),
        .wrap  (x_wrap)
    );

    assign y_en = p_tick & x_wrap;

    mod_counter #(.MAX(V_TOT), .W(COORD_W)) u_y (
        .clk   (clk),
        .reset (reset),
        .en    (y_en),
        .q     (y),
        .wrap  (y_wrap)
    );

    // Values the counters will hold after this edge; decoding the sync windows
    // from these keeps the registered syncs in step with x/y.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (x_wrap) begin
            x_nxt = '0;
        end else if (p_tick) begin
            x_nxt = x + COORD_W'(1);
        end
        if (y_wrap) begin
            y_nxt = '0;
        end else if (y_en) begin
            y_nxt = y + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync      <= ~SYNC_ACTIVE;
            vsync      <= ~SYNC_ACTIVE;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= in_window(x_nxt, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync      <= in_window(y_nxt, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            // y_wrap already implies x_wrap and p_tick: both counters return to 0.
            frame_tick <= y_wrap;
        end
    end

    assign video_on = (x < H_VIS) && (y < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and reduced timing)
module tb_vga_sync_gen;

    // Reduced timing for the second instance so whole frames fit in a short run.
    localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 3;
    localparam int SV_D = 6, SV_F = 2, SV_S = 2, SV_B = 2;
    localparam int S_FRAME = 4 * (SH_D + SH_F + SH_S + SH_B) * (SV_D + SV_F + SV_S + SV_B);

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic       hs0, vs0, vo0, pt0, ft0;
    logic       hs1, vs1, vo1, pt1, ft1;
    logic [9:0] x0, y0, x1, y1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut0 (
        .clk(clk), .reset(rst0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
        .p_tick(pt0), .x(x0), .y(y0), .frame_tick(ft0)
    );

    vga_sync_gen #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
        .p_tick(pt1), .x(x1), .y(y1), .frame_tick(ft1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int x; int y; bit pt; bit hs; bit vs; bit vo; bit ft;
    } exp_t;

    // Expected outputs n clk edges after reset release, from timing arithmetic.
    function automatic exp_t model(input int n, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb);
        exp_t m;
        int ht  = hd + hf + hsw + hb;
        int vt  = vd + vf + vsw + vb;
        int pix = n / 4;
        m.x  = pix % ht;
        m.y  = (pix / ht) % vt;
        m.pt = (n % 4) == 3;
        m.hs = !(m.x >= hd + hf && m.x < hd + hf + hsw);
        m.vs = !(m.y >= vd + vf && m.y < vd + vf + vsw);
        m.vo = (m.x < hd) && (m.y < vd);
        m.ft = (n > 0) && (n % (4 * ht * vt) == 0);
        return m;
    endfunction

    task automatic check_d0(input int n);
        exp_t m = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
        chk("d0_x", x0, m.x);
        chk("d0_y", y0, m.y);
        chk("d0_p_tick", pt0, m.pt);
        chk("d0_hsync", hs0, m.hs);
        chk("d0_vsync", vs0, m.vs);
        chk("d0_video_on", vo0, m.vo);
        chk("d0_frame_tick", ft0, m.ft);
    endtask

    task automatic check_d1(input int n);
        exp_t m = model(n, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B);
        chk("d1_x", x1, m.x);
        chk("d1_y", y1, m.y);
        chk("d1_p_tick", pt1, m.pt);
        chk("d1_hsync", hs1, m.hs);
        chk("d1_vsync", vs1, m.vs);
        chk("d1_video_on", vo1, m.vo);
        chk("d1_frame_tick", ft1, m.ft);
    endtask

    task automatic check_reset_vals(input string tag, input logic [9:0] xv, input logic [9:0] yv,
                                    input logic hs, input logic vs, input logic vo,
                                    input logic pt, input logic ft);
        chk({tag, "_x"}, xv, 0);
        chk({tag, "_y"}, yv, 0);
        chk({tag, "_hsync"}, hs, 1);
        chk({tag, "_vsync"}, vs, 1);
        chk({tag, "_video_on"}, vo, 1);
        chk({tag, "_p_tick"}, pt, 0);
        chk({tag, "_frame_tick"}, ft, 0);
    endtask

    initial begin
        int hs_low_cnt    = 0;
        int hs_first_x    = -1;
        int vs_low_cnt    = 0;
        int ft_cnt        = 0;
        int ft_last       = -1;
        int refresh_cnt   = 0;
        int refresh_ptick = 0;
        bit found;

        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_vals("rst_d0", x0, y0, hs0, vs0, vo0, pt0, ft0);
        check_reset_vals("rst_d1", x1, y1, hs1, vs1, vo1, pt1, ft1);

        rst0 = 1'b0;
        rst1 = 1'b0;

        for (int n = 1; n <= 3400; n++) begin
            @(negedge clk);
            if (n == 3) chk("first_p_tick", pt0, 1);
            if (n == 4) chk("first_x_step", x0, 1);
            check_d0(n);
            check_d1(n);

            if (n <= 3200 && hs0 == 1'b0) begin
                if (hs_first_x < 0) hs_first_x = int'(x0);
                hs_low_cnt++;
            end
            if (n == 3200) begin
                chk("line_wrap_x", x0, 0);
                chk("line_wrap_y", y0, 1);
            end
            if (x0 == 10'd639 && y0 == 10'd0 && pt0) chk("vo_639_0", vo0, 1);
            if (x0 == 10'd640 && y0 == 10'd0 && pt0) chk("vo_640_0", vo0, 0);

            if (n <= S_FRAME) begin
                if (vs1 == 1'b0) vs_low_cnt++;
                if (y1 == 10'(SV_D + 1) && x1 == 10'd0) begin
                    refresh_cnt++;
                    if (pt1) refresh_ptick++;
                end
            end
            if (x1 == 10'(SH_D - 1) && y1 == 10'(SV_D - 1) && pt1) chk("vo_last_vis", vo1, 1);
            if (x1 == 10'(SH_D) && y1 == 10'd0 && pt1) chk("vo_h_blank", vo1, 0);
            if (x1 == 10'd0 && y1 == 10'(SV_D) && pt1) chk("vo_v_blank", vo1, 0);
            if (x1 == 10'(SH_D + SH_F + SH_S + SH_B - 1) &&
                y1 == 10'(SV_D + SV_F + SV_S + SV_B - 1) && pt1) chk("vo_corner", vo1, 0);

            if (ft1) begin
                if (ft_last >= 0) chk("frame_period", n - ft_last, S_FRAME);
                ft_last = n;
                ft_cnt++;
            end
        end

        chk("hsync_low_clks", hs_low_cnt, 384);
        chk("hsync_first_x", hs_first_x, 656);
        chk("vsync_low_clks", vs_low_cnt, 2 * 4 * (SH_D + SH_F + SH_S + SH_B));
        chk("frame_tick_count", ft_cnt, 3400 / S_FRAME);
        chk("refresh_clks", refresh_cnt, 4);
        chk("refresh_p_tick", refresh_ptick, 1);

        // Mid-frame asynchronous reset of the reduced instance.
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            @(negedge clk);
            found = (x1 == 10'd5) && (y1 == 10'd4);
        end
        chk("mid_point_reached", found, 1);
        #1 rst1 = 1'b1;
        #1 check_reset_vals("async_rst", x1, y1, hs1, vs1, vo1, pt1, ft1);
        @(negedge clk);
        rst1 = 1'b0;
        for (int n = 1; n <= S_FRAME + 40; n++) begin
            @(negedge clk);
            check_d1(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
